serial_slave_port: RTL and testbench

Bus-side responder for the serial system bus: deserialises address and write data arriving bit-serially from the bus interconnect on a slave lane, performs the access on a local single-port memory with one-cycle read latency, and serialises read data back to the interconnect. Sits between one slave lane of the interconnect and a slave's local BRAM. It is the responder-side counterpart of the master port.

---
 rtl/serial_slave_port.sv | 173 +++++++++++++++++
 tb/tb_serial_slave_port.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : serial_slave_port
// Brief    : Bit-serial bus responder; deserialises address/write data, drives
//            a one-cycle-latency local memory and serialises read data back.
//            Optional split support is built when SSP_SPLIT_EN is defined.
// Revision : 1.0
// ============================================================================
module serial_slave_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  swdata,
   input  logic                  smode,
   input  logic                  mvalid,
   output logic                  srdata,
   output logic                  svalid,
   output logic                  sready,
   output logic                  ssplit,
   input  logic                  split_grant,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wen,
   output logic                  mem_ren,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int c_MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int c_CNT_W = (c_MAX_W > 1) ? $clog2(c_MAX_W) : 1;
   localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] c_S_IDLE  = 3'd0;
   localparam logic [2:0] c_S_ADDR  = 3'd1;
   localparam logic [2:0] c_S_WDATA = 3'd2;
   localparam logic [2:0] c_S_MEMWR = 3'd3;
   localparam logic [2:0] c_S_MEMRD = 3'd4;
   localparam logic [2:0] c_S_RWAIT = 3'd5;
`ifdef SSP_SPLIT_EN
   localparam logic [2:0] c_S_SPLIT = 3'd6;
`endif
   localparam logic [2:0] c_S_RDATA = 3'd7;

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic [c_CNT_W-1:0]    r_cnt;
   logic                  w_count;
   logic                  r_mode;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] w_wdata_nxt;
   logic [DATA_WIDTH-1:0] r_rbuf;
   logic [DATA_WIDTH-1:0] w_rbuf_nxt;
   logic                  w_srdata_nxt;
   logic                  w_ssplit_nxt;

   assign w_count = (((r_state == c_S_ADDR) || (r_state == c_S_WDATA)) && mvalid)
                    || (r_state == c_S_RDATA);

   // State register; the counter restarts on every state change except the
   // IDLE capture, which has already consumed address bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= ((r_state == c_S_IDLE) && (w_next == c_S_ADDR)) ? c_CNT_W'(1) : '0;
         else if (w_count)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_S_IDLE:  if (mvalid)
                       w_next = (ADDR_WIDTH == 1) ? (smode ? c_S_WDATA : c_S_MEMRD) : c_S_ADDR;
         c_S_ADDR:  if (mvalid && (r_cnt == c_ADDR_LAST))
                       w_next = r_mode ? c_S_WDATA : c_S_MEMRD;
         c_S_WDATA: if (mvalid && (r_cnt == c_DATA_LAST))
                       w_next = c_S_MEMWR;
         c_S_MEMWR: w_next = c_S_IDLE;
         c_S_MEMRD: w_next = c_S_RWAIT;
`ifdef SSP_SPLIT_EN
         c_S_RWAIT: w_next = c_S_SPLIT;
         c_S_SPLIT: if (split_grant)
                       w_next = c_S_RDATA;
`else
         c_S_RWAIT: w_next = c_S_RDATA;
`endif
         c_S_RDATA: if (r_cnt == c_DATA_LAST)
                       w_next = c_S_IDLE;
         default:   w_next = c_S_IDLE;
      endcase
   end

   // Shift-position capture written as a compare loop so the counter width
   // never has to match either field's index width.
   always_comb begin
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      if (mvalid && (r_state == c_S_IDLE))
         w_addr_nxt[0] = swdata;
      for (int i = 0; i < ADDR_WIDTH; i++)
         if (mvalid && (r_state == c_S_ADDR) && (r_cnt == c_CNT_W'(i)))
            w_addr_nxt[i] = swdata;
      for (int i = 0; i < DATA_WIDTH; i++)
         if (mvalid && (r_state == c_S_WDATA) && (r_cnt == c_CNT_W'(i)))
            w_wdata_nxt[i] = swdata;
   end

   // srdata is registered, so it is loaded with the bit for the coming cycle.
   always_comb begin
      w_rbuf_nxt   = (r_state == c_S_RWAIT) ? mem_rdata : r_rbuf;
      w_srdata_nxt = 1'b0;
      if (w_next == c_S_RDATA) begin
         if (r_state != c_S_RDATA)
            w_srdata_nxt = w_rbuf_nxt[0];
         else
            for (int i = 1; i < DATA_WIDTH; i++)
               if (r_cnt == c_CNT_W'(i - 1))
                  w_srdata_nxt = r_rbuf[i];
      end
   end

`ifdef SSP_SPLIT_EN
   assign w_ssplit_nxt = (r_state == c_S_RWAIT);
`else
   logic w_unused_split_grant;
   assign w_unused_split_grant = split_grant;
   assign w_ssplit_nxt         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode    <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rbuf    <= '0;
         srdata    <= 1'b0;
         svalid    <= 1'b0;
         sready    <= 1'b0;
         ssplit    <= 1'b0;
         mem_wen   <= 1'b0;
         mem_ren   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if ((r_state == c_S_IDLE) && mvalid)
            r_mode <= smode;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_rbuf  <= w_rbuf_nxt;
         srdata  <= w_srdata_nxt;
         svalid  <= (w_next == c_S_RDATA);
         sready  <= (w_next == c_S_IDLE);
         ssplit  <= w_ssplit_nxt;
         mem_wen <= (w_next == c_S_MEMWR);
         mem_ren <= (w_next == c_S_MEMRD);
         if ((w_next == c_S_MEMWR) || (w_next == c_S_MEMRD))
            mem_addr <= w_addr_nxt;
         if (w_next == c_S_MEMWR)
            mem_wdata <= w_wdata_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_slave_port
// Brief    : Scoreboard bench for serial_slave_port with a local BRAM model;
//            covers the SSP_SPLIT_EN build when that macro is defined.
// Revision : 1.0
// ============================================================================
module tb_serial_slave_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        swdata;
   logic        smode;
   logic        mvalid;
   logic        srdata;
   logic        svalid;
   logic        sready;
   logic        ssplit;
   logic        split_grant;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_wen;
   logic        mem_ren;
   logic [7:0]  mem_rdata;

   serial_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .swdata(swdata), .smode(smode), .mvalid(mvalid),
      .srdata(srdata), .svalid(svalid), .sready(sready), .ssplit(ssplit),
      .split_grant(split_grant), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [7:0]  data;
      int          cyc;   // write: mem_wen cycle; read: first svalid (or ssplit) cycle
   } exp_t;

   exp_t        sb[$];
   exp_t        wen_e;
   exp_t        cur;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          split_gap = -1;
   int          grant_cyc = -1;
   int          gap;
   int          rd_n = 0;
   logic [7:0]  rd_bits = '0;
   int          sready_due = -1;
   logic        prev_ssplit = 1'b0;
   logic [7:0]  ref_mem [0:4095];
   logic [7:0]  bram    [0:4095];
   logic [11:0] ra;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_val(input int a);
      return 8'((a * 97 + 13) & 255);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sready"}, sready, 0);
      chk({tag, "_svalid"}, svalid, 0);
      chk({tag, "_srdata"}, srdata, 0);
      chk({tag, "_ssplit"}, ssplit, 0);
      chk({tag, "_mem_wen"}, mem_wen, 0);
      chk({tag, "_mem_ren"}, mem_ren, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   // Local single-port memory: read data appears the cycle after mem_ren.
   initial begin
      for (int i = 0; i < 4096; i++) bram[i] = init_val(i);
      bram[12'h07F] = 8'h5A;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         if (mem_ren) mem_rdata <= bram[mem_addr];
         if (mem_wen) bram[mem_addr] = mem_wdata;
      end
   end

   // Split grant source: split build grants after a chosen gap, otherwise noise.
   initial begin
      split_grant = 1'b0;
      forever begin
         @(negedge clk);
`ifdef SSP_SPLIT_EN
         if (!rst && ssplit) begin
            if (sb.size() != 0) chk("ssplit_cycle", cyc, sb[0].cyc);
            else                chk("ssplit_unexpected", 1, 0);
            gap = (split_gap >= 0) ? split_gap : $urandom_range(0, 10);
            repeat (gap) @(negedge clk);
            split_grant = 1'b1;
            grant_cyc   = cyc;
            @(negedge clk);
            split_grant = 1'b0;
         end
`else
         split_grant = 1'($urandom);
`endif
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a write or a read stream.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            rd_n        = 0;
            sready_due  = -1;
            prev_ssplit = 1'b0;
         end else begin
            if (sready_due == cyc) begin
               chk("sready_return", sready, 1);
               sready_due = -1;
            end
`ifdef SSP_SPLIT_EN
            if (prev_ssplit) chk("ssplit_pulse", ssplit, 0);
            prev_ssplit = ssplit;
`endif
            if (mem_wen) begin
               if (sb.size() == 0) chk("wen_unexpected", 1, 0);
               else begin
                  wen_e = sb.pop_front();
                  chk("wen_is_write", 32'(wen_e.wr), 1);
                  chk("wen_cycle", cyc, wen_e.cyc);
                  chk("wen_addr", mem_addr, wen_e.addr);
                  chk("wen_data", mem_wdata, wen_e.data);
                  chk("wen_sready_low", sready, 0);
                  chk("wen_ssplit", ssplit, 0);
                  sready_due = cyc + 1;
               end
            end
            if (svalid) begin
               if (rd_n == 0) begin
                  if (sb.size() == 0) chk("rd_unexpected", 1, 0);
                  else begin
                     cur = sb.pop_front();
                     chk("rd_is_read", 32'(cur.wr), 0);
`ifdef SSP_SPLIT_EN
                     chk("rd_first_cycle", cyc, grant_cyc + 1);
`else
                     chk("rd_first_cycle", cyc, cur.cyc);
                     chk("rd_ssplit", ssplit, 0);
`endif
                  end
               end
               chk("rd_sready_low", sready, 0);
               rd_bits = {srdata, rd_bits[7:1]};
               rd_n++;
               if (rd_n == 8) begin
                  chk("rd_data", rd_bits, cur.data);
                  rd_n       = 0;
                  sready_due = cyc + 1;
               end
            end else if (rd_n != 0) begin
               chk("rd_svalid_gap", 0, 1);
               rd_n = 0;
            end
         end
      end
   end

   // Issues one transaction LSB first. sa_*/sd_* insert fixed stalls before the
   // given address/data bit, pct adds random stalls, stop_after truncates.
   task automatic send(input bit wr, input logic [11:0] a, input logic [7:0] d,
                       input int sa_pos, input int sa_n, input int sd_pos, input int sd_n,
                       input int pct, input int stop_after);
      int          guard;
      int          nbits;
      logic [19:0] bits;
      guard = 0;
      while (sready !== 1'b1) begin
         @(posedge clk); #1;
         guard++;
         if (guard > 100) begin
            chk("sready_timeout", sready, 1);
            return;
         end
      end
      nbits = wr ? 20 : 12;
      bits  = {d, a};
      for (int i = 0; i < nbits; i++) begin
         int ns;
         if (i == stop_after) begin
            mvalid = 1'b0;
            return;
         end
         ns = 0;
         if (i == sa_pos)                 ns = sa_n;
         else if (wr && i == 12 + sd_pos) ns = sd_n;
         else if (i > 0 && $urandom_range(0, 99) < pct) ns = $urandom_range(1, 2);
         repeat (ns) begin
            mvalid = 1'b0;
            swdata = 1'($urandom);
            smode  = 1'($urandom);
            @(posedge clk); #1;
         end
         mvalid = 1'b1;
         swdata = bits[i];
         smode  = (i == 0) ? wr : 1'($urandom);
         if (i == nbits - 1) begin
            sb.push_back('{wr, a, wr ? d : ref_mem[a], cyc + (wr ? 1 : 3)});
            if (wr) ref_mem[a] = d;
         end
         @(posedge clk); #1;
      end
      mvalid = 1'b0;
      swdata = 1'b0;
      smode  = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst    = 1'b1;
      swdata = 1'b0;
      smode  = 1'b0;
      mvalid = 1'b0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
      ref_mem[12'h07F] = 8'h5A;

      @(posedge clk); #1;
      chk_reset_outputs("por");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("por_sready_after", sready, 1);

      send(1'b1, 12'h3C1, 8'hA5, -1, 0, -1, 0, 0, -1);
      split_gap = 10;
      send(1'b0, 12'h07F, 8'h00, -1, 0, -1, 0, 0, -1);
      split_gap = -1;
      send(1'b1, 12'h2A6, 8'hC3, 5, 3, 4, 2, 0, -1);
      send(1'b1, 12'h001, 8'h11, -1, 0, -1, 0, 0, -1);
      send(1'b0, 12'h001, 8'h00, -1, 0, -1, 0, 0, -1);

      // Abort a write after six address bits with reset.
      send(1'b1, 12'h2B7, 8'h3D, -1, 0, -1, 0, 0, 6);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs("midrst");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_sready_after", sready, 1);
      send(1'b1, 12'h555, 8'h96, -1, 0, -1, 0, 0, -1);
      send(1'b0, 12'h2B7, 8'h00, -1, 0, -1, 0, 0, -1);

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 4))
            0:       ra = 12'h001;
            1:       ra = 12'h07F;
            2:       ra = 12'hFFF;
            3:       ra = 12'h800;
            default: ra = 12'($urandom);
         endcase
         send(1'($urandom_range(0, 1)), ra, 8'($urandom), -1, 0, -1, 0, 30, -1);
      end

      for (int w = 0; w < 300; w++) begin
         if (sb.size() == 0 && rd_n == 0 && sready_due < 0) break;
         @(posedge clk); #1;
      end
      chk("drain_scoreboard", sb.size(), 0);
      chk("drain_final_sready", sready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
